// File: rtl/upsample2d2x_if.sv
// Stream bundle for the 2x upsampler: pixel input handshake and output handshake with frame marker.
interface upsample2d2x_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  valid_in;
    logic                  ready_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic                  ready_out;
    logic                  last_out;

    modport master (
        output data_in, valid_in, ready_out,
        input  ready_in, data_out, valid_out, last_out
    );

    modport slave (
        input  data_in, valid_in, ready_out,
        output ready_in, data_out, valid_out, last_out
    );
endinterface

// File: rtl/upsample2d2x.sv
// Streaming 2x nearest-neighbour upsampler: even rows pass live pixels (each emitted twice),
// odd rows replay the previous even row from a one-row buffer.
module upsample2d2x #(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_SIZE   = 13
) (
    input logic           Clk,
    input logic           Rst,
    upsample2d2x_if.slave bus
);
    localparam int OUT_SIZE = 2 * IMG_SIZE;
    localparam int POS_W    = $clog2(OUT_SIZE);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(OUT_SIZE - 1);

    logic [POS_W-1:0]      pos_row;
    logic [POS_W-1:0]      pos_col;
    logic [DATA_WIDTH-1:0] row_buf [IMG_SIZE];
    logic [DATA_WIDTH-1:0] data_p0;
    logic                  vld_p0;
    logic                  last_p0;

    logic             slot_free;
    logic             live;
    logic             load;
    logic             accept;
    logic             col_wrap;
    logic             at_last;
    logic [POS_W-2:0] buf_idx;

    assign slot_free = !vld_p0 || bus.ready_out;
    assign live      = !pos_row[0] && !pos_col[0];
    assign buf_idx   = pos_col[POS_W-1:1];
    assign col_wrap  = (pos_col == POS_LAST);
    assign at_last   = col_wrap && (pos_row == POS_LAST);

    // Live slots wait for upstream; duplicate and replay slots always have a beat ready.
    assign load         = slot_free && (!live || bus.valid_in);
    assign bus.ready_in = Rst && live && slot_free;
    assign accept       = bus.ready_in && bus.valid_in;

    // Output register stage (p0)
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            pos_row <= '0;
            pos_col <= '0;
            data_p0 <= '0;
            vld_p0  <= 1'b0;
            last_p0 <= 1'b0;
        end else if (slot_free) begin
            vld_p0  <= load;
            last_p0 <= load && at_last;
            if (load) begin
                if (live) begin
                    data_p0 <= bus.data_in;
                end else if (pos_row[0]) begin
                    data_p0 <= row_buf[buf_idx];
                end
                pos_col <= col_wrap ? '0 : pos_col + POS_W'(1);
                if (col_wrap) begin
                    pos_row <= (pos_row == POS_LAST) ? '0 : pos_row + POS_W'(1);
                end
            end
        end
    end

    // Row buffer is always written in an even row before the following odd row reads it.
    always_ff @(posedge Clk) begin
        if (accept) begin
            row_buf[buf_idx] <= bus.data_in;
        end
    end

    assign bus.data_out  = data_p0;
    assign bus.valid_out = vld_p0;
    assign bus.last_out  = last_p0;
endmodule

// File: tb/tb_upsample2d2x.sv
// Directed bench for upsample2d2x: a 2x2 and a 4x4 instance driven from shared stimulus.
module tb_upsample2d2x;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] din;
    logic        vin;
    logic        rout;
    logic        sel;
    logic [31:0] o_d;
    logic        o_v;
    logic        o_l;
    logic        o_r;
    int          tests = 0;
    int          fails = 0;
    int          beats, rdy_cnt, first_cyc, last_cyc;

    always #5 clk = ~clk;

    upsample2d2x_if #(.DATA_WIDTH(32)) if_a ();
    upsample2d2x_if #(.DATA_WIDTH(32)) if_b ();

    assign if_a.data_in   = din;
    assign if_a.valid_in  = vin;
    assign if_a.ready_out = rout;
    assign if_b.data_in   = din;
    assign if_b.valid_in  = vin;
    assign if_b.ready_out = rout;

    upsample2d2x #(.DATA_WIDTH(32), .IMG_SIZE(2)) dut_a (.Clk(clk), .Rst(rst_n), .bus(if_a));
    upsample2d2x #(.DATA_WIDTH(32), .IMG_SIZE(4)) dut_b (.Clk(clk), .Rst(rst_n), .bus(if_b));

    always_comb begin
        o_d = if_a.data_out;
        o_v = if_a.valid_out;
        o_l = if_a.last_out;
        o_r = if_a.ready_in;
        if (sel) begin
            o_d = if_b.data_out;
            o_v = if_b.valid_out;
            o_l = if_b.last_out;
            o_r = if_b.ready_in;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Output index idx (within repeating frames) is an even-row, even-column position.
    function automatic bit live_pos(input int n, input int idx);
        int k, r, c;
        k = idx % (4 * n * n);
        r = k / (2 * n);
        c = k % (2 * n);
        return (r % 2 == 0) && (c % 2 == 0);
    endfunction

    task automatic run(input int n, input int frames, input int vmode, input int rmode,
                       input int base, input int stop_after,
                       output int nbeats, output int nrdy, output int fcyc, output int lcyc);
        int          frame;
        int          total;
        int          acc;
        int          cyc;
        int          cool;
        int          loaded, f, k, r, c;
        logic [31:0] s_d;
        logic        s_v, s_l, stalled, exp_rdy;
        frame   = 4 * n * n;
        total   = frames * frame;
        acc     = 0;
        cyc     = 0;
        cool    = 0;
        nbeats  = 0;
        nrdy    = 0;
        fcyc    = -1;
        lcyc    = -1;
        stalled = 1'b0;
        s_d     = '0;
        s_v     = 1'b0;
        s_l     = 1'b0;
        @(posedge clk); #1;
        while (nbeats < total && (stop_after == 0 || nbeats < stop_after) && cyc < 2000) begin
            if (stalled) begin
                chk("stall_data", o_d, s_d);
                chk("stall_valid", o_v, s_v);
                chk("stall_last", o_l, s_l);
            end
            loaded = nbeats + (o_v ? 1 : 0);
            if (!o_v) chk("gap_pos", live_pos(n, loaded), 1);
            rout = (rmode == 1) ? (cyc % 2 == 0) : 1'b1;
            vin  = (acc < frames * n * n) && (vmode == 0 || cool == 0);
            din  = base + acc;
            #1;
            exp_rdy = live_pos(n, loaded) && (!o_v || rout);
            chk("ready_in", o_r, exp_rdy);
            if (o_r && loaded < total) nrdy++;
            if (o_v && rout) begin
                f = nbeats / frame;
                k = nbeats % frame;
                r = k / (2 * n);
                c = k % (2 * n);
                chk("data_out", o_d, base + f * n * n + (r / 2) * n + c / 2);
                chk("last_out", o_l, k == frame - 1);
                if (fcyc < 0) fcyc = cyc;
                lcyc = cyc;
                nbeats++;
            end
            if (vin && o_r) begin
                acc++;
                cool = 2;
            end else if (cool > 0) begin
                cool--;
            end
            stalled = o_v && !rout;
            s_d     = o_d;
            s_v     = o_v;
            s_l     = o_l;
            cyc++;
            @(posedge clk); #1;
        end
        vin  = 1'b0;
        rout = 1'b1;
        chk("beat_count", nbeats, (stop_after == 0) ? total : stop_after);
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #11 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        vin   = 1'b0;
        rout  = 1'b1;
        din   = '0;
        sel   = 1'b0;
        #12;
        chk("rst_a_data", o_d, 0);
        chk("rst_a_valid", o_v, 0);
        chk("rst_a_last", o_l, 0);
        chk("rst_a_ready", o_r, 0);
        sel = 1'b1;
        #1;
        chk("rst_b_data", o_d, 0);
        chk("rst_b_valid", o_v, 0);
        chk("rst_b_ready", o_r, 0);
        #9 rst_n = 1'b1;

        // 2x2, continuous input, no backpressure
        sel = 1'b0;
        run(2, 1, 0, 0, 1, 0, beats, rdy_cnt, first_cyc, last_cyc);
        chk("t1_latency", first_cyc, 1);
        chk("t1_span", last_cyc - first_cyc + 1, 16);
        chk("t1_ready_cnt", rdy_cnt, 4);

        // 4x4, ready_out toggling
        pulse_reset();
        sel = 1'b1;
        run(4, 1, 0, 1, 0, 0, beats, rdy_cnt, first_cyc, last_cyc);

        // 4x4, valid_in every third cycle
        pulse_reset();
        run(4, 1, 1, 0, 0, 0, beats, rdy_cnt, first_cyc, last_cyc);

        // 4x4, pixel 0xA5 presented throughout the first replay row
        pulse_reset();
        run(4, 1, 0, 0, 32'hA1, 0, beats, rdy_cnt, first_cyc, last_cyc);
        chk("t4_ready_cnt", rdy_cnt, 16);

        // 4x4, reset mid-frame then a fresh frame
        pulse_reset();
        run(4, 1, 0, 0, 0, 20, beats, rdy_cnt, first_cyc, last_cyc);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_data", o_d, 0);
        chk("t5_rst_valid", o_v, 0);
        chk("t5_rst_last", o_l, 0);
        chk("t5_rst_ready", o_r, 0);
        #10 rst_n = 1'b1;
        run(4, 1, 0, 0, 100, 0, beats, rdy_cnt, first_cyc, last_cyc);
        chk("t5_span", last_cyc - first_cyc + 1, 64);

        // 2x2, two back-to-back frames
        pulse_reset();
        sel = 1'b0;
        run(2, 2, 0, 0, 1, 0, beats, rdy_cnt, first_cyc, last_cyc);
        chk("t6_span", last_cyc - first_cyc + 1, 32);
        chk("t6_ready_cnt", rdy_cnt, 8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
